// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALU operation classes and the datapath mux select codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] immSrcFor(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an ALU operation class plus instruction fields to the ALU function code.
// Purely combinational so the single-cycle core can reuse it unchanged.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_t     aluOp,
    input  logic [2:0] funct3,
    input  logic       opb5,
    input  logic       funct7b5,
    output logic [2:0] aluControl
);

    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  aluControl = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControl = ALU_SLT;
                    3'b110:  aluControl = ALU_OR;
                    3'b111:  aluControl = ALU_AND;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the shared-memory multicycle RV32I datapath, with a memory
// ready handshake and a retired-instruction counter.
//
//   state      | meaning
//   S_FETCH    | read instruction at PC, PC <= PC+4 once memory is ready
//   S_DECODE   | compute branch target into ALUOut, dispatch on opcode
//   S_MEMADR   | effective address = rs1 + imm
//   S_MEMREAD  | load access, waits for mem_ready
//   S_MEMWB    | write loaded data to rd, retire
//   S_MEMWRITE | store access, strobe held until mem_ready, retire
//   S_EXECR    | register-register ALU op
//   S_EXECI    | register-immediate ALU op
//   S_ALUWB    | write ALUOut to rd, retire
//   S_BEQ      | compare, take branch on zero, retire
//   S_JAL      | PC <= target, link value OldPC+4 into ALUOut
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic             instr_retire,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_count
);

    state_t state, nextState;
    aluop_t aluOp;
    logic   pcWriteRaw, memWriteRaw, irWriteRaw, regWriteRaw, retireRaw, illegalRaw;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_FETCH;
            retired_count <= '0;
        end else begin
            state <= nextState;
            if (retireRaw) retired_count <= retired_count + CNT_W'(1);
        end
    end

    always_comb begin
        nextState   = state;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        aluOp       = ALUOP_ADD;
        pcWriteRaw  = 1'b0;
        memWriteRaw = 1'b0;
        irWriteRaw  = 1'b0;
        regWriteRaw = 1'b0;
        retireRaw   = 1'b0;
        illegalRaw  = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (mem_ready) begin
                    irWriteRaw = 1'b1;
                    pcWriteRaw = 1'b1;
                    nextState  = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: nextState = S_MEMADR;
                    OP_RTYPE:          nextState = S_EXECR;
                    OP_ITYPE:          nextState = S_EXECI;
                    OP_BRANCH:         nextState = S_BEQ;
                    OP_JAL:            nextState = S_JAL;
                    default: begin
                        nextState  = S_FETCH;
                        illegalRaw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                nextState = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) nextState = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                regWriteRaw = 1'b1;
                retireRaw   = 1'b1;
                nextState   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                memWriteRaw = 1'b1;
                if (mem_ready) begin
                    retireRaw = 1'b1;
                    nextState = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA   = SRCA_RD1;
                aluOp     = ALUOP_FUNCT;
                nextState = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                aluOp     = ALUOP_FUNCT;
                nextState = S_ALUWB;
            end
            S_ALUWB: begin
                regWriteRaw = 1'b1;
                retireRaw   = 1'b1;
                nextState   = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RD1;
                aluOp      = ALUOP_SUB;
                pcWriteRaw = zero;
                retireRaw  = 1'b1;
                nextState  = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pcWriteRaw = 1'b1;
                nextState  = S_ALUWB;
            end
            default: nextState = S_FETCH;
        endcase
    end

    // Write enables and pulses are suppressed while reset is held so an
    // abandoned instruction never commits anything.
    assign PCWrite      = reset & pcWriteRaw;
    assign MemWrite     = reset & memWriteRaw;
    assign IRWrite      = reset & irWriteRaw;
    assign RegWrite     = reset & regWriteRaw;
    assign instr_retire = reset & retireRaw;
    assign illegal_op   = reset & illegalRaw;
    assign ImmSrc       = immSrcFor(op);

    alu_decoder aluDec (
        .aluOp      (aluOp),
        .funct3     (funct3),
        .opb5       (op[5]),
        .funct7b5   (funct7b5),
        .aluControl (ALUControl)
    );

endmodule
